font_loader: RTL
================

// Module: font_loader
// PURPOSE
//   Writer side of the MDA character-glyph EBRs. Accepts a framed byte stream
//   (e.g. from a UART receiver) and drives the write port of one of the
//   per-glyph-row 512x8 block RAMs. Allows run-time font replacement without
//   resynthesis. Sits between the host byte link and the glyph memory banks.
// PARAMETERS
//   NUM_BANKS      14       glyph-row EBRs (one per character scanline)
//   SYNC_BYTE      8'hA5    frame start marker
//   TIMEOUT_CYCLES 1000000  max idle cycles between bytes inside a frame
// PORTS
//   clk        in   1  system clock, all logic on posedge
//   resetn     in   1  asynchronous, active-low reset
//   s_data     in   8  incoming byte
//   s_valid    in   1  s_data valid
//   s_ready    out  1  loader accepts byte (transfer = s_valid & s_ready)
//   wbank      out  4  target EBR index, 0..NUM_BANKS-1
//   waddr      out  9  byte address within bank
//   wdata      out  8  byte to write
//   wen        out  1  write strobe, one cycle per data byte
//   done       out  1  one-cycle pulse at frame end
//   status_ok  out  1  result of last frame (1 = good), held until next done
// BEHAVIOUR
//   Reset: all outputs 0 except s_ready=1; state IDLE; timeout counter 0.
//   Frame: SYNC, BANK, ADDR_HI(bit0 = addr[8], others ignored), ADDR_LO,
//     LEN_HI(bit0), LEN_LO, LEN data bytes, CSUM.
//   LEN is 9 bits; LEN=0 means 512. CSUM = 8-bit sum of data bytes mod 256.
//   States: IDLE -> BANK -> AHI -> ALO -> LHI -> LLO -> DATA -> CSUM -> DONE.
//     IDLE: non-SYNC bytes consumed and discarded.
//     Each header state advances on one accepted byte.
//     DATA: stays until LEN bytes accepted. CSUM: one byte, then DONE.
//     DONE: lasts one cycle, s_ready=0, done=1; then IDLE.
//   s_ready=1 in every state except DONE.
//   Write: a data byte accepted in cycle N gives wen=1 in cycle N+1, with
//     wbank, waddr, wdata registered. Writes are back-to-back at full rate.
//     wen=0 in every other cycle.
//   Address: starts at header address and increments by 1 per data byte.
//     It wraps 511 -> 0 (mod 512). Length and bank are never affected.
//   Bad bank (BANK >= NUM_BANKS): the frame is still parsed and all data
//     bytes consumed, but wen is never asserted; status_ok=0 at done.
//   Checksum: status_ok = (CSUM byte == running sum) && bank valid.
//     Writes are not rolled back on mismatch.
//   Timeout: in any state other than IDLE/DONE, the counter increments on
//     cycles with no accepted byte and clears on each accepted byte.
//     On reaching TIMEOUT_CYCLES-1: go to IDLE, done=0, status_ok=0.
//     No further wen is issued.
//   Simultaneous events: the last DATA byte and the timeout limit in the same
//     cycle -> the byte wins (accepted, counter cleared).
//   Reset mid-frame: immediate abort. A pending wen is dropped (EBR contents
//     may be partially written). status_ok=0.
//   status_ok and done update in the same cycle; status_ok holds otherwise.
// STRUCTURE
//   Shared package: state enum (IDLE..DONE), SYNC_BYTE default,
//     ADDR_W=9, DATA_W=8, BANK_W=4.
//   One natural sub-module: font_loader_timeout (loadable idle counter with
//     clear/enable, terminal-count output). Everything else stays in this
//     module: FSM, header registers, address/length counters, checksum, and
//     write-port register stage.
//   Top level decodes wbank into per-EBR wen one-hot (not this block).
// TESTING
//   1. Frame A5,03,00,10,00,02,41,42,83 ->
//      wen at bank3 addr 0x010=41, 0x011=42; done=1; status_ok=1.
//   2. Start 0x1FF, LEN=2 ->
//      writes to addr 0x1FF then 0x000 (wrap); status_ok=1 with good CSUM.
//   3. BANK=14, LEN=3 ->
//      no wen, 3 data bytes consumed, done=1, status_ok=0; next frame OK.
//   4. Good frame with CSUM off by one ->
//      all data written, done=1, status_ok=0.
//   5. Stall TIMEOUT_CYCLES after ADDR_LO ->
//      return to IDLE, no done, status_ok=0; a fresh frame then succeeds.
//   6. resetn low during DATA (after 5 of 10 bytes) ->
//      wen=0 immediately; outputs at reset values; garbage bytes ignored
//      until SYNC.
//   Also check: LEN=0 writes 512 bytes; s_ready=0 exactly one cycle at DONE.

Source files
------------

// File: rtl/font_loader_pkg.sv
// rtl/font_loader_pkg.sv - shared types and widths for the glyph-RAM font loader
package font_loader_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int BANK_W = 4;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_BANK,
        ST_AHI,
        ST_ALO,
        ST_LHI,
        ST_LLO,
        ST_DATA,
        ST_CSUM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/font_loader_timeout.sv
// rtl/font_loader_timeout.sv - idle-cycle counter with clear/enable and terminal-count flag
module font_loader_timeout #(
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    // Saturates at the terminal value so the flag stays up until cleared.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TERM)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TERM);

endmodule

// File: rtl/font_loader.sv
// rtl/font_loader.sv - parses framed byte stream and drives the glyph EBR write port
module font_loader
    import font_loader_pkg::*;
#(
    parameter int NUM_BANKS      = 14,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [BANK_W-1:0] wbank,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              wen,
    output logic              done,
    output logic              status_ok
);

    localparam logic [DATA_W-1:0] NUM_BANKS_B = DATA_W'(NUM_BANKS);

    state_t state, state_next;

    logic              xfer;
    logic              idle_clear;
    logic              timed_out;
    logic              abort;
    logic [BANK_W-1:0] bank_r;
    logic              bank_ok;
    logic [ADDR_W-1:0] addr_r;
    logic              len_hi;
    logic [ADDR_W:0]   len_left;
    logic [DATA_W-1:0] sum;

    assign s_ready    = (state != ST_DONE);
    assign xfer       = s_valid && s_ready;
    assign idle_clear = xfer || (state == ST_IDLE) || (state == ST_DONE);
    // An accepted byte always beats an expiring idle counter.
    assign abort      = timed_out && !xfer && (state != ST_IDLE) && (state != ST_DONE);

    font_loader_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .resetn (resetn),
        .clear  (idle_clear),
        .enable (!idle_clear),
        .expired(timed_out)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (xfer && (s_data == SYNC_BYTE)) state_next = ST_BANK;
            ST_BANK: if (xfer) state_next = ST_AHI;
            ST_AHI:  if (xfer) state_next = ST_ALO;
            ST_ALO:  if (xfer) state_next = ST_LHI;
            ST_LHI:  if (xfer) state_next = ST_LLO;
            ST_LLO:  if (xfer) state_next = ST_DATA;
            ST_DATA: if (xfer && (len_left == (ADDR_W+1)'(1))) state_next = ST_CSUM;
            ST_CSUM: if (xfer) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bank_r    <= '0;
            bank_ok   <= 1'b0;
            addr_r    <= '0;
            len_hi    <= 1'b0;
            len_left  <= '0;
            sum       <= '0;
            wen       <= 1'b0;
            wbank     <= '0;
            waddr     <= '0;
            wdata     <= '0;
            done      <= 1'b0;
            status_ok <= 1'b0;
        end else begin
            wen  <= 1'b0;
            done <= 1'b0;
            if (xfer) begin
                case (state)
                    ST_BANK: begin
                        bank_r  <= s_data[BANK_W-1:0];
                        bank_ok <= (s_data < NUM_BANKS_B);
                        sum     <= '0;
                    end
                    ST_AHI: addr_r[ADDR_W-1] <= s_data[0];
                    ST_ALO: addr_r[ADDR_W-2:0] <= s_data;
                    ST_LHI: len_hi <= s_data[0];
                    // A zero length field encodes a full 512-byte bank.
                    ST_LLO: len_left <= ({len_hi, s_data} == '0) ? (ADDR_W+1)'(512)
                                                                 : {1'b0, len_hi, s_data};
                    ST_DATA: begin
                        wen      <= bank_ok;
                        wbank    <= bank_r;
                        waddr    <= addr_r;
                        wdata    <= s_data;
                        addr_r   <= addr_r + 1'b1;
                        len_left <= len_left - 1'b1;
                        sum      <= sum + s_data;
                    end
                    ST_CSUM: begin
                        done      <= 1'b1;
                        status_ok <= (s_data == sum) && bank_ok;
                    end
                    default: ;
                endcase
            end
            if (abort) begin
                status_ok <= 1'b0;
            end
        end
    end

endmodule
